// File: rtl/spart_core_if.sv
// Processor I/O bus control signals shared by the SPART register interface.
interface spart_core_if;
  logic       iocs_n;
  logic       iorw_n;
  logic [1:0] ioaddr;

  modport master (output iocs_n, output iorw_n, output ioaddr);
  modport slave  (input  iocs_n, input  iorw_n, input  ioaddr);
endinterface

// File: rtl/spart_core.sv
// SPART: 8N1 UART with 8-entry TX/RX queues, status register and 16-bit baud
// divisor, all reached over a shared bidirectional 8-bit I/O bus.
module spart_core #(
  parameter int unsigned QDEPTH   = 8,
  parameter logic [15:0] DB_RESET = 16'h0364
) (
  input  logic         clk,
  input  logic         rst_n,
  spart_core_if.slave  bus,
  inout  wire  [7:0]   databus,
  input  logic         RX,
  output logic         TX,
  output logic         tx_q_full,
  output logic         rx_q_empty
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QDEPTH);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Bus decode
  logic       bus_rd_c;
  logic       bus_wr_c;
  logic [7:0] rd_data_c;

  // Baud divisor
  logic [15:0] db_q;

  // TX queue
  logic [7:0]       tx_mem_q [QDEPTH];
  logic [PTR_W-1:0] tx_wptr_q;
  logic [PTR_W-1:0] tx_rptr_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [CNT_W-1:0] tx_cnt_d;
  logic             tx_push_c;
  logic             tx_pop_c;
  logic             tx_q_empty_c;

  // RX queue
  logic [7:0]       rx_mem_q [QDEPTH];
  logic [PTR_W-1:0] rx_wptr_q;
  logic [PTR_W-1:0] rx_rptr_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [CNT_W-1:0] rx_cnt_d;
  logic             rx_push_c;
  logic             rx_pop_c;

  // TX engine
  tx_state_e   tx_state_q;
  tx_state_e   tx_state_d;
  logic [15:0] tx_tmr_q;
  logic [15:0] tx_tmr_d;
  logic [2:0]  tx_idx_q;
  logic [2:0]  tx_idx_d;
  logic [7:0]  tx_data_q;
  logic [7:0]  tx_data_d;
  logic        tx_line_q;
  logic        tx_line_d;
  logic        tx_done_c;

  // RX engine
  rx_state_e   rx_state_q;
  rx_state_e   rx_state_d;
  logic        rx_s1_q;
  logic        rx_s2_q;
  logic        rx_prev_q;
  logic        rx_fall_c;
  logic [15:0] rx_tmr_q;
  logic [15:0] rx_tmr_d;
  logic [2:0]  rx_idx_q;
  logic [2:0]  rx_idx_d;
  logic [7:0]  rx_shift_q;
  logic [7:0]  rx_shift_d;
  logic        rx_rdy_c;

  assign bus_rd_c = ~bus.iocs_n &  bus.iorw_n;
  assign bus_wr_c = ~bus.iocs_n & ~bus.iorw_n;

  assign tx_push_c    = bus_wr_c && (bus.ioaddr == 2'b00) && (tx_cnt_q != CNT_FULL);
  assign rx_pop_c     = bus_rd_c && (bus.ioaddr == 2'b00) && (rx_cnt_q != '0);
  assign rx_push_c    = rx_rdy_c && (rx_cnt_q != CNT_FULL);
  assign tx_q_empty_c = (tx_cnt_q == '0);

  assign tx_cnt_d = tx_cnt_q + CNT_W'(tx_push_c) - CNT_W'(tx_pop_c);
  assign rx_cnt_d = rx_cnt_q + CNT_W'(rx_push_c) - CNT_W'(rx_pop_c);

  assign tx_done_c = (tx_state_q == TX_STOP) && (tx_tmr_q == 16'd0);
  assign rx_fall_c = rx_prev_q & ~rx_s2_q;
  assign rx_rdy_c  = (rx_state_q == RX_STOP) && (rx_tmr_q == 16'd0);

  assign TX = tx_line_q;

  // Read data mux; only driven onto the bus during a read access
  always_comb begin
    rd_data_c = 8'h00;
    unique case (bus.ioaddr)
      2'b00: if (rx_cnt_q != '0) rd_data_c = rx_mem_q[rx_rptr_q];
      2'b01: rd_data_c = {4'(CNT_FULL - tx_cnt_q), 4'(rx_cnt_q)};
      2'b10: rd_data_c = db_q[7:0];
      2'b11: rd_data_c = db_q[15:8];
      default: rd_data_c = 8'h00;
    endcase
  end

  assign databus = bus_rd_c ? rd_data_c : 8'hzz;

  // Baud divisor register, byte-writable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_q <= DB_RESET;
    end else if (bus_wr_c) begin
      if (bus.ioaddr == 2'b10) db_q[7:0]  <= databus;
      if (bus.ioaddr == 2'b11) db_q[15:8] <= databus;
    end
  end

  // TX queue pointers, occupancy and full flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      tx_q_full <= 1'b0;
    end else begin
      if (tx_push_c) tx_wptr_q <= tx_wptr_q + PTR_W'(1);
      if (tx_pop_c)  tx_rptr_q <= tx_rptr_q + PTR_W'(1);
      tx_cnt_q  <= tx_cnt_d;
      tx_q_full <= (tx_cnt_d == CNT_FULL);
    end
  end

  // TX queue storage
  always_ff @(posedge clk) begin
    if (tx_push_c) tx_mem_q[tx_wptr_q] <= databus;
  end

  // RX queue pointers, occupancy and empty flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_cnt_q   <= '0;
      rx_q_empty <= 1'b1;
    end else begin
      if (rx_push_c) rx_wptr_q <= rx_wptr_q + PTR_W'(1);
      if (rx_pop_c)  rx_rptr_q <= rx_rptr_q + PTR_W'(1);
      rx_cnt_q   <= rx_cnt_d;
      rx_q_empty <= (rx_cnt_d == '0);
    end
  end

  // RX queue storage
  always_ff @(posedge clk) begin
    if (rx_push_c) rx_mem_q[rx_wptr_q] <= rx_shift_q;
  end

  // TX engine state register
  always_ff @(posedge clk) begin
    if (!rst_n) tx_state_q <= TX_IDLE;
    else        tx_state_q <= tx_state_d;
  end

  // TX engine next-state: frame sequencing on bit-timer expiry
  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      TX_IDLE:  if (!tx_q_empty_c) tx_state_d = TX_START;
      TX_START: if (tx_tmr_q == 16'd0) tx_state_d = TX_DATA;
      TX_DATA:  if ((tx_tmr_q == 16'd0) && (tx_idx_q == 3'd7)) tx_state_d = TX_STOP;
      TX_STOP:  if (tx_done_c) tx_state_d = TX_IDLE;
      default:  tx_state_d = TX_IDLE;
    endcase
  end

  // TX engine outputs: head pop, bit timer reload (picks up the current divisor), line level
  always_comb begin
    tx_pop_c  = 1'b0;
    tx_tmr_d  = tx_tmr_q;
    tx_idx_d  = tx_idx_q;
    tx_data_d = tx_data_q;
    tx_line_d = 1'b1;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (!tx_q_empty_c) begin
          tx_pop_c  = 1'b1;
          tx_data_d = tx_mem_q[tx_rptr_q];
          tx_tmr_d  = db_q - 16'd1;
          tx_idx_d  = 3'd0;
        end
      end
      TX_START: begin
        tx_line_d = 1'b0;
        tx_tmr_d  = (tx_tmr_q == 16'd0) ? db_q - 16'd1 : tx_tmr_q - 16'd1;
      end
      TX_DATA: begin
        tx_line_d = tx_data_q[tx_idx_q];
        if (tx_tmr_q == 16'd0) begin
          tx_tmr_d = db_q - 16'd1;
          tx_idx_d = tx_idx_q + 3'd1;
        end else begin
          tx_tmr_d = tx_tmr_q - 16'd1;
        end
      end
      TX_STOP: begin
        tx_line_d = 1'b1;
        if (!tx_done_c) tx_tmr_d = tx_tmr_q - 16'd1;
      end
      default: tx_line_d = 1'b1;
    endcase
  end

  // TX datapath registers; line idles high and is forced high by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_tmr_q  <= '0;
      tx_idx_q  <= '0;
      tx_data_q <= '0;
      tx_line_q <= 1'b1;
    end else begin
      tx_tmr_q  <= tx_tmr_d;
      tx_idx_q  <= tx_idx_d;
      tx_data_q <= tx_data_d;
      tx_line_q <= tx_line_d;
    end
  end

  // RX input synchronizer plus delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= RX;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // RX engine state register
  always_ff @(posedge clk) begin
    if (!rst_n) rx_state_q <= RX_IDLE;
    else        rx_state_q <= rx_state_d;
  end

  // RX engine next-state: start detection, false-start reject, bit sequencing
  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      RX_IDLE:  if (rx_fall_c) rx_state_d = RX_START;
      RX_START: if (rx_tmr_q == 16'd0) rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if ((rx_tmr_q == 16'd0) && (rx_idx_q == 3'd7)) rx_state_d = RX_STOP;
      RX_STOP:  if (rx_rdy_c) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  // RX engine outputs: half-bit wait to mid start bit, then full-bit shift strobes
  always_comb begin
    rx_tmr_d   = rx_tmr_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall_c) rx_tmr_d = (db_q >> 1) - 16'd1;
      end
      RX_START: begin
        if (rx_tmr_q == 16'd0) begin
          rx_tmr_d = db_q - 16'd1;
          rx_idx_d = 3'd0;
        end else begin
          rx_tmr_d = rx_tmr_q - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_tmr_q == 16'd0) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_idx_d   = rx_idx_q + 3'd1;
          rx_tmr_d   = db_q - 16'd1;
        end else begin
          rx_tmr_d = rx_tmr_q - 16'd1;
        end
      end
      RX_STOP: begin
        if (!rx_rdy_c) rx_tmr_d = rx_tmr_q - 16'd1;
      end
      default: rx_tmr_d = rx_tmr_q;
    endcase
  end

  // RX datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_tmr_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_tmr_q   <= rx_tmr_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
    end
  end

endmodule

// File: tb/tb_spart_core.sv
// Self-checking bench for spart_core: bus register access, TX framing and
// timing, RX reception, queue limits and mid-frame reset.
module tb_spart_core;

  localparam int BT_DEF  = 868;
  localparam int BT_FAST = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_drv;
  logic       tx_line;
  logic       tx_q_full;
  logic       rx_q_empty;
  wire  [7:0] databus;
  logic [7:0] tb_data;
  logic       tb_oe;

  int errors = 0;
  int checks = 0;

  bit         tx_trace[$];
  logic [7:0] tx_exp_q[$];
  bit         cap_got;

  always #5 clk = ~clk;

  assign databus = tb_oe ? tb_data : 8'hzz;

  spart_core_if bus_if ();

  spart_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus_if),
    .databus    (databus),
    .RX         (rx_drv),
    .TX         (tx_line),
    .tx_q_full  (tx_q_full),
    .rx_q_empty (rx_q_empty)
  );

  // ---------------- bus / line helpers ----------------
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_if.iocs_n = 1'b0; bus_if.iorw_n = 1'b0; bus_if.ioaddr = a;
    tb_data = d; tb_oe = 1'b1;
    @(negedge clk);
    bus_if.iocs_n = 1'b1; bus_if.iorw_n = 1'b1; tb_oe = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    bus_if.iocs_n = 1'b0; bus_if.iorw_n = 1'b1; bus_if.ioaddr = a; tb_oe = 1'b0;
    #1 d = databus;
    @(negedge clk);
    bus_if.iocs_n = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int bt);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx_drv = bits[i];
      repeat (bt) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  // Wait (bounded) for a start bit on TX, then record one frame, one sample per clock
  task automatic capture_tx(input int bt, input int limit, output bit got);
    int waited;
    waited = 0;
    got = 1'b0;
    tx_trace.delete();
    while (waited < limit) begin
      @(negedge clk);
      waited++;
      if (tx_line === 1'b0) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      tx_trace.push_back(1'b0);
      for (int i = 1; i < 10 * bt; i++) begin
        @(negedge clk);
        tx_trace.push_back(tx_line === 1'b1);
      end
    end
  endtask

  function automatic logic [7:0] trace_byte(input int bt);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < 8; k++) b[k] = tx_trace[bt / 2 + (k + 1) * bt];
    return b;
  endfunction

  function automatic bit trace_framed(input int bt);
    return (tx_trace[bt / 2] == 1'b0) && (tx_trace[9 * bt + bt / 2] == 1'b1);
  endfunction

  function automatic int run_len(input int start);
    int n;
    bit lvl;
    n = 0;
    lvl = tx_trace[start];
    for (int i = start; i < tx_trace.size(); i++) begin
      if (tx_trace[i] != lvl) break;
      n++;
    end
    return n;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] rd;
    rst_n = 1'b0; rx_drv = 1'b1; tb_oe = 1'b0; tb_data = 8'h00;
    bus_if.iocs_n = 1'b1; bus_if.iorw_n = 1'b1; bus_if.ioaddr = 2'b00;
    repeat (3) @(negedge clk);
    checks++; if (tx_line !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx_line); end
    checks++; if (tx_q_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", tx_q_full); end
    checks++; if (rx_q_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", rx_q_empty); end
    rst_n = 1'b1;
    bus_read(2'b01, rd);
    checks++; if (rd !== 8'h80) begin errors++; $display("FAIL reset_status: got %h want 80", rd); end
    bus_read(2'b10, rd);
    checks++; if (rd !== 8'h64) begin errors++; $display("FAIL reset_db_lo: got %h want 64", rd); end
    bus_read(2'b11, rd);
    checks++; if (rd !== 8'h03) begin errors++; $display("FAIL reset_db_hi: got %h want 03", rd); end
    bus_read(2'b00, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL reset_empty_read: got %h want 00", rd); end
  endtask

  // Write held 9 clocks fills queue (8 queued + 1 in flight); extra writes drop
  task automatic test_fill_and_bit_time();
    logic [7:0] fill_d [12];
    logic [7:0] rd;
    fill_d[0] = 8'h55;
    fill_d[1] = 8'($urandom) & 8'hFE;
    for (int i = 2; i < 12; i++) fill_d[i] = 8'($urandom);
    fork
      capture_tx(BT_DEF, 50, cap_got);
      begin
        @(negedge clk);
        bus_if.iocs_n = 1'b0; bus_if.iorw_n = 1'b0; bus_if.ioaddr = 2'b00; tb_oe = 1'b1;
        for (int i = 0; i < 9; i++) begin
          tb_data = fill_d[i];
          @(negedge clk);
        end
        checks++; if (tx_q_full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", tx_q_full); end
        for (int i = 9; i < 12; i++) begin
          tb_data = fill_d[i];
          @(negedge clk);
        end
        bus_if.iocs_n = 1'b1; bus_if.iorw_n = 1'b1; tb_oe = 1'b0;
        bus_read(2'b01, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL fill_status: got %h want 00", rd); end
      end
    join
    checks++; if (cap_got !== 1'b1) begin errors++; $display("FAIL fill_frame_start: got %b want 1", cap_got); end
    if (cap_got) begin
      checks++; if (trace_byte(BT_DEF) !== 8'h55) begin errors++; $display("FAIL fill_frame_data: got %h want 55", trace_byte(BT_DEF)); end
      checks++; if (run_len(0) != BT_DEF) begin errors++; $display("FAIL fill_start_width: got %0d want %0d", run_len(0), BT_DEF); end
      checks++; if (run_len(BT_DEF) != BT_DEF) begin errors++; $display("FAIL fill_bit0_width: got %0d want %0d", run_len(BT_DEF), BT_DEF); end
    end
  endtask

  // Second frame (bit0 = 0) is in flight; RX start bit in progress; then reset
  task automatic test_reset_mid_frame();
    logic [7:0] rd;
    repeat (1000) @(negedge clk);
    rx_drv = 1'b0;
    repeat (200) @(negedge clk);
    checks++; if (tx_line !== 1'b0) begin errors++; $display("FAIL midrst_pre_tx: got %b want 0", tx_line); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (tx_line !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b want 1", tx_line); end
    checks++; if (tx_q_full !== 1'b0) begin errors++; $display("FAIL midrst_full: got %b want 0", tx_q_full); end
    checks++; if (rx_q_empty !== 1'b1) begin errors++; $display("FAIL midrst_empty: got %b want 1", rx_q_empty); end
    rx_drv = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(2'b01, rd);
    checks++; if (rd !== 8'h80) begin errors++; $display("FAIL midrst_status: got %h want 80", rd); end
    repeat (1000) @(negedge clk);
    checks++; if (tx_line !== 1'b1) begin errors++; $display("FAIL midrst_tx_idle: got %b want 1", tx_line); end
    checks++; if (rx_q_empty !== 1'b1) begin errors++; $display("FAIL midrst_no_rx: got %b want 1", rx_q_empty); end
  endtask

  task automatic test_divisor();
    logic [15:0] vals [3];
    logic [7:0]  lo, hi;
    vals[0] = 16'h0364; vals[1] = 16'h00D9; vals[2] = 16'h1458;
    for (int i = 0; i < 3; i++) begin
      bus_write(2'b10, vals[i][7:0]);
      bus_write(2'b11, vals[i][15:8]);
      bus_read(2'b10, lo);
      bus_read(2'b11, hi);
      checks++; if ({hi, lo} !== vals[i]) begin errors++; $display("FAIL divisor_%0d: got %h want %h", i, {hi, lo}, vals[i]); end
    end
    bus_write(2'b10, 8'(BT_FAST));
    bus_write(2'b11, 8'h00);
  endtask

  task automatic test_tx_random();
    int n;
    logic [7:0] rd;
    n = int'($urandom_range(3, 8));
    tx_exp_q.delete();
    for (int i = 0; i < n; i++) tx_exp_q.push_back(8'($urandom));
    fork
      begin
        for (int i = 0; i < n; i++) bus_write(2'b00, tx_exp_q[i]);
      end
      begin
        for (int k = 0; k < n; k++) begin
          capture_tx(BT_FAST, 400, cap_got);
          checks++;
          if (!cap_got) begin errors++; $display("FAIL tx_rand_%0d: no start bit", k); end
          else if (trace_byte(BT_FAST) !== tx_exp_q[k] || !trace_framed(BT_FAST)) begin
            errors++; $display("FAIL tx_rand_%0d: got %h framed %b want %h framed 1", k, trace_byte(BT_FAST), trace_framed(BT_FAST), tx_exp_q[k]);
          end
        end
      end
    join
    bus_read(2'b01, rd);
    checks++; if (rd !== 8'h80) begin errors++; $display("FAIL tx_rand_drained: got %h want 80", rd); end
  endtask

  // 12 writes while idle: first one goes straight to the line, 8 queue, rest dropped
  task automatic test_tx_overflow();
    logic [7:0] wr_d [12];
    for (int i = 0; i < 12; i++) wr_d[i] = 8'($urandom);
    tx_exp_q.delete();
    for (int i = 0; i < 9; i++) tx_exp_q.push_back(wr_d[i]);
    fork
      begin
        for (int i = 0; i < 12; i++) bus_write(2'b00, wr_d[i]);
        checks++; if (tx_q_full !== 1'b1) begin errors++; $display("FAIL tx_ovf_full: got %b want 1", tx_q_full); end
      end
      begin
        for (int k = 0; k < 9; k++) begin
          capture_tx(BT_FAST, 400, cap_got);
          checks++;
          if (!cap_got) begin errors++; $display("FAIL tx_ovf_%0d: no start bit", k); end
          else if (trace_byte(BT_FAST) !== tx_exp_q[k] || !trace_framed(BT_FAST)) begin
            errors++; $display("FAIL tx_ovf_%0d: got %h framed %b want %h framed 1", k, trace_byte(BT_FAST), trace_framed(BT_FAST), tx_exp_q[k]);
          end
        end
      end
    join
    capture_tx(BT_FAST, 3 * BT_FAST, cap_got);
    checks++; if (cap_got !== 1'b0) begin errors++; $display("FAIL tx_ovf_extra_frame: got %b want 0", cap_got); end
  endtask

  task automatic test_rx_random();
    logic [7:0] exp_q[$];
    logic [7:0] rd;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'($urandom));
    for (int i = 0; i < 7; i++) send_frame(exp_q[i], BT_FAST);
    repeat (2 * BT_FAST) @(negedge clk);
    checks++; if (rx_q_empty !== 1'b0) begin errors++; $display("FAIL rx_rand_nonempty: got %b want 0", rx_q_empty); end
    bus_read(2'b01, rd);
    checks++; if (rd !== 8'h87) begin errors++; $display("FAIL rx_rand_status: got %h want 87", rd); end
    for (int i = 0; i < 7; i++) begin
      bus_read(2'b00, rd);
      checks++; if (rd !== exp_q[i]) begin errors++; $display("FAIL rx_rand_%0d: got %h want %h", i, rd, exp_q[i]); end
    end
    checks++; if (rx_q_empty !== 1'b1) begin errors++; $display("FAIL rx_rand_empty: got %b want 1", rx_q_empty); end
    bus_read(2'b00, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rx_rand_empty_read: got %h want 00", rd); end
  endtask

  task automatic test_rx_overflow();
    logic [7:0] sent [10];
    logic [7:0] rd;
    for (int i = 0; i < 10; i++) sent[i] = 8'($urandom);
    for (int i = 0; i < 10; i++) send_frame(sent[i], BT_FAST);
    repeat (2 * BT_FAST) @(negedge clk);
    bus_read(2'b01, rd);
    checks++; if (rd !== 8'h88) begin errors++; $display("FAIL rx_ovf_status: got %h want 88", rd); end
    for (int i = 0; i < 8; i++) begin
      bus_read(2'b00, rd);
      checks++; if (rd !== sent[i]) begin errors++; $display("FAIL rx_ovf_%0d: got %h want %h", i, rd, sent[i]); end
    end
    checks++; if (rx_q_empty !== 1'b1) begin errors++; $display("FAIL rx_ovf_empty: got %b want 1", rx_q_empty); end
  endtask

  // Short low glitch: start bit reads high at mid-point, nothing received
  task automatic test_false_start();
    logic [7:0] rd;
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * BT_FAST) @(negedge clk);
    checks++; if (rx_q_empty !== 1'b1) begin errors++; $display("FAIL false_start_empty: got %b want 1", rx_q_empty); end
    bus_read(2'b01, rd);
    checks++; if (rd !== 8'h80) begin errors++; $display("FAIL false_start_status: got %h want 80", rd); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd;
    fork
      send_frame(8'hFF, BT_FAST);
      bus_write(2'b00, 8'hFF);
      capture_tx(BT_FAST, 200, cap_got);
    join
    repeat (BT_FAST) @(negedge clk);
    checks++; if (rx_q_empty !== 1'b0) begin errors++; $display("FAIL b2b_rx_nonempty: got %b want 0", rx_q_empty); end
    checks++;
    if (!cap_got) begin errors++; $display("FAIL b2b_tx: no start bit"); end
    else if (trace_byte(BT_FAST) !== 8'hFF || !trace_framed(BT_FAST)) begin
      errors++; $display("FAIL b2b_tx: got %h framed %b want ff framed 1", trace_byte(BT_FAST), trace_framed(BT_FAST));
    end
    bus_read(2'b00, rd);
    checks++; if (rd !== 8'hFF) begin errors++; $display("FAIL b2b_rx_data: got %h want ff", rd); end
    checks++; if (rx_q_empty !== 1'b1) begin errors++; $display("FAIL b2b_rx_empty: got %b want 1", rx_q_empty); end
  endtask

  task automatic test_default_divisor_frame();
    bus_write(2'b10, 8'h64);
    bus_write(2'b11, 8'h03);
    bus_write(2'b00, 8'hAA);
    capture_tx(BT_DEF, 100, cap_got);
    checks++; if (cap_got !== 1'b1) begin errors++; $display("FAIL aa_start: got %b want 1", cap_got); end
    if (cap_got) begin
      checks++; if (trace_byte(BT_DEF) !== 8'hAA) begin errors++; $display("FAIL aa_data: got %h want aa", trace_byte(BT_DEF)); end
      checks++; if (!trace_framed(BT_DEF)) begin errors++; $display("FAIL aa_framing: got 0 want 1"); end
      checks++; if (run_len(0) != 2 * BT_DEF) begin errors++; $display("FAIL aa_low_run: got %0d want %0d", run_len(0), 2 * BT_DEF); end
      checks++; if (run_len(2 * BT_DEF) != BT_DEF) begin errors++; $display("FAIL aa_high_run: got %0d want %0d", run_len(2 * BT_DEF), BT_DEF); end
    end
  endtask

  initial begin
    test_reset();
    test_fill_and_bit_time();
    test_reset_mid_frame();
    test_divisor();
    test_tx_random();
    test_tx_overflow();
    test_rx_random();
    test_rx_overflow();
    test_false_start();
    test_back_to_back();
    test_default_divisor_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
